// File: rtl/seq_mult_scheduler_if.sv
// Requester, response and multiplier-side signals of the scheduler.
// master = requester/multiplier environment, slave = scheduler.
interface seq_mult_scheduler_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 4
);
  logic                       req0_valid, req1_valid;
  logic                       req0_ready, req1_ready;
  logic [A_WIDTH-1:0]         req0_a, req1_a;
  logic [B_WIDTH-1:0]         req0_b, req1_b;
  logic                       rsp_valid, rsp_id;
  logic [A_WIDTH+B_WIDTH-1:0] rsp_product;
  logic                       busy;
  logic [15:0]                jobs_done;
  logic [A_WIDTH-1:0]         mul_a;
  logic [B_WIDTH-1:0]         mul_b;
  logic                       mul_write, mul_multiply, mul_display;
  logic [A_WIDTH+B_WIDTH-1:0] mul_out;

  modport master (
    output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, mul_out,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy,
           jobs_done, mul_a, mul_b, mul_write, mul_multiply, mul_display
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, mul_out,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy,
           jobs_done, mul_a, mul_b, mul_write, mul_multiply, mul_display
  );
endinterface

// File: rtl/seq_mult_scheduler.sv
// Round-robin sharing of one sequential_multiplier between two requesters;
// sequences write -> multiply -> display and returns the id-tagged product.
module seq_mult_scheduler #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 4,
  parameter int MULT_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_mult_scheduler_if.slave bus
);
  localparam int PW = A_WIDTH + B_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, MULT, SHOW, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               job_id_q, job_id_d;
  logic [A_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [B_WIDTH-1:0] mul_b_q, mul_b_d;
  logic               mul_write_q, mul_write_d;
  logic               mul_multiply_q, mul_multiply_d;
  logic               mul_display_q, mul_display_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [PW-1:0]      rsp_product_q, rsp_product_d;
  logic [15:0]        jobs_done_q, jobs_done_d;
  logic               gnt1, idle, hs;

  // Lone requester wins; otherwise the one not granted last time.
  assign gnt1 = (bus.req1_valid & ~bus.req0_valid) |
                (~(bus.req0_valid ^ bus.req1_valid) & ~last_grant_q);
  assign idle = (state_q == IDLE);
  assign bus.req0_ready = rst_n & idle & ~gnt1;
  assign bus.req1_ready = rst_n & idle & gnt1;
  assign hs = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    job_id_d      = job_id_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_product_d = rsp_product_q;
    jobs_done_d   = jobs_done_q;
    case (state_q)
      IDLE: if (hs) begin
        mul_a_d      = gnt1 ? bus.req1_a : bus.req0_a;
        mul_b_d      = gnt1 ? bus.req1_b : bus.req0_b;
        job_id_d     = gnt1;
        last_grant_d = gnt1;
        state_d      = LOAD;
      end
      LOAD: begin
        cnt_d   = 4'(MULT_CYCLES - 1);
        state_d = MULT;
      end
      MULT: if (cnt_q == 4'd0) begin
        cnt_d   = 4'd1;
        state_d = SHOW;
      end else cnt_d = cnt_q - 4'd1;
      // The multiplier's out is only settled on the second display cycle.
      SHOW: if (cnt_q == 4'd0) begin
        rsp_product_d = bus.mul_out;
        jobs_done_d   = jobs_done_q + 16'd1;
        state_d       = DONE;
      end else cnt_d = cnt_q - 4'd1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mul_write_d    = (state_d == LOAD);
    mul_multiply_d = (state_d == MULT);
    mul_display_d  = (state_d == SHOW);
    rsp_valid_d    = (state_d == DONE);
    rsp_id_d       = (state_d == DONE) & job_id_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_grant_q   <= 1'b1;
      job_id_q       <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_write_q    <= 1'b0;
      mul_multiply_q <= 1'b0;
      mul_display_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_product_q  <= '0;
      jobs_done_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      job_id_q       <= job_id_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_write_q    <= mul_write_d;
      mul_multiply_q <= mul_multiply_d;
      mul_display_q  <= mul_display_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_product_q  <= rsp_product_d;
      jobs_done_q    <= jobs_done_d;
    end
  end

  assign bus.busy         = ~idle;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.mul_write    = mul_write_q;
  assign bus.mul_multiply = mul_multiply_q;
  assign bus.mul_display  = mul_display_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_product  = rsp_product_q;
  assign bus.jobs_done    = jobs_done_q;
endmodule

// File: tb/tb_seq_mult_scheduler.sv
// Bench for seq_mult_scheduler: shift-add multiplier model, timeline scoreboard,
// vector table, contention/fairness/reset sequences and random traffic.
module tb_seq_mult_scheduler;
  localparam int AW = 8, BW = 4, MC = 4, PW = AW + BW, LAT = MC + 4;

  logic gclk = 1'b0, grst_n = 1'b0;
  always #5 gclk = ~gclk;

  seq_mult_scheduler_if #(.A_WIDTH(AW), .B_WIDTH(BW)) bus();
  seq_mult_scheduler #(.A_WIDTH(AW), .B_WIDTH(BW), .MULT_CYCLES(MC)) dut (
    .clk(gclk), .rst_n(grst_n), .bus(bus)
  );

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Shift-add multiplier: one b bit per multiply cycle, out follows display one cycle late.
  logic [PW-1:0] m_acc, m_out;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  int            m_idx;
  always @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      m_acc <= '0; m_out <= '0; m_a <= '0; m_b <= '0; m_idx <= 0;
    end else begin
      if (bus.mul_write) begin
        m_a <= bus.mul_a; m_b <= bus.mul_b; m_acc <= '0; m_idx <= 0;
      end
      if (bus.mul_multiply && m_idx < BW) begin
        if (m_b[m_idx]) m_acc <= m_acc + (PW'(m_a) << m_idx);
        m_idx <= m_idx + 1;
      end
      m_out <= bus.mul_display ? m_acc : '0;
    end
  end
  assign bus.mul_out = m_out;

  // Scoreboard: everything follows from the handshake cycle and fixed offsets.
  int            cyc = 0, hs_cyc = 0;
  bit            job_act = 0, lg = 1, j_id = 0;
  logic [AW-1:0] j_a = '0, cur_a = '0;
  logic [BW-1:0] j_b = '0, cur_b = '0;
  logic [PW-1:0] prod_exp = '0;
  logic [15:0]   jobs_exp = '0;
  int            grants[$];

  always @(negedge gclk) begin
    int ph;
    bit bsy, g, hs;
    if (!grst_n) begin
      chk("reset_outs", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                         bus.busy, bus.mul_write, bus.mul_multiply, bus.mul_display}, 0);
      chk("reset_data", {bus.rsp_product, bus.jobs_done} | {bus.mul_a, bus.mul_b}, 0);
      job_act = 0; lg = 1; jobs_exp = '0; prod_exp = '0; cur_a = '0; cur_b = '0;
    end else begin
      cyc++;
      ph  = cyc - hs_cyc;
      bsy = job_act && ph >= 1 && ph <= LAT;
      if (job_act && ph == 1) begin cur_a = j_a; cur_b = j_b; end
      if (job_act && ph == LAT) begin
        prod_exp = PW'(j_a) * PW'(j_b);
        jobs_exp = jobs_exp + 16'd1;
      end
      g = (bus.req1_valid && !bus.req0_valid) ||
          ((bus.req0_valid == bus.req1_valid) && !lg);
      chk("ready0", bus.req0_ready, !bsy && !g);
      chk("ready1", bus.req1_ready, !bsy && g);
      chk("ready_excl", bus.req0_ready & bus.req1_ready, 0);
      chk("busy", bus.busy, bsy);
      chk("ctl_wmd", {bus.mul_write, bus.mul_multiply, bus.mul_display},
          {job_act && ph == 1, job_act && ph >= 2 && ph <= MC + 1,
           job_act && ph >= MC + 2 && ph <= MC + 3});
      chk("rsp_valid", bus.rsp_valid, job_act && ph == LAT);
      chk("rsp_id", bus.rsp_id, job_act && ph == LAT && j_id);
      chk("rsp_product", bus.rsp_product, prod_exp);
      chk("jobs_done", bus.jobs_done, jobs_exp);
      chk("mul_a", bus.mul_a, cur_a);
      chk("mul_b", bus.mul_b, cur_b);
      hs = !bsy && (g ? bus.req1_valid : bus.req0_valid);
      if (hs) begin
        hs_cyc = cyc; job_act = 1; j_id = g; lg = g;
        j_a = g ? bus.req1_a : bus.req0_a;
        j_b = g ? bus.req1_b : bus.req0_b;
        grants.push_back(int'(g));
      end
    end
  end

  task automatic do_reset();
    @(posedge gclk); #1 grst_n = 1'b0;
    repeat (2) @(posedge gclk);
    #1 grst_n = 1'b1;
  endtask

  task automatic one_job(input bit id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                         output int lat, output bit rid, output logic [PW-1:0] prod);
    int n;
    @(posedge gclk); #1;
    if (id) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; end
    n = 0;
    do begin @(negedge gclk); n++; end
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50);
    chk("job_accept_timeout", n < 50, 1);
    @(posedge gclk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    lat = 0;
    do begin @(negedge gclk); lat++; end while (!bus.rsp_valid && lat < 50);
    rid = bus.rsp_id; prod = bus.rsp_product;
  endtask

  typedef struct {
    bit            id;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [PW-1:0] prod;
  } vec_t;
  vec_t vec[8];

  initial begin
    int lat, n;
    bit rid;
    logic [PW-1:0] prod;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    vec[0] = '{0, 8'd200, 4'd13, 12'd2600};
    vec[1] = '{1, 8'd3,   4'd5,  12'd15};
    vec[2] = '{0, 8'd255, 4'd15, 12'd3825};
    vec[3] = '{1, 8'd10,  4'd10, 12'd100};
    vec[4] = '{1, 8'd0,   4'd15, 12'd0};
    vec[5] = '{0, 8'd255, 4'd0,  12'd0};
    vec[6] = '{0, 8'd1,   4'd1,  12'd1};
    vec[7] = '{1, 8'd128, 4'd8,  12'd1024};

    repeat (3) @(posedge gclk);
    #1 grst_n = 1'b1;
    @(negedge gclk);
    chk("post_reset_jobs", bus.jobs_done, 0);
    chk("post_reset_ready0", bus.req0_ready, 1);

    for (int i = 0; i < 8; i++) begin
      one_job(vec[i].id, vec[i].a, vec[i].b, lat, rid, prod);
      chk($sformatf("vec%0d_lat", i), lat, LAT);
      chk($sformatf("vec%0d_id", i), rid, vec[i].id);
      chk($sformatf("vec%0d_prod", i), prod, vec[i].prod);
    end
    chk("vec_jobs_done", bus.jobs_done, 8);

    // Contention from reset release: req0 first, req1 one job period later.
    @(posedge gclk); #1 grst_n = 1'b0;
    bus.req0_valid = 1; bus.req0_a = 8'd3;   bus.req0_b = 4'd5;
    bus.req1_valid = 1; bus.req1_a = 8'd255; bus.req1_b = 4'd15;
    repeat (2) @(posedge gclk);
    #1 grst_n = 1'b1;
    @(negedge gclk);
    chk("cont_ready0", bus.req0_ready, 1);
    @(posedge gclk); #1 bus.req0_valid = 0;
    for (int k = 1; k <= LAT + 9; k++) begin
      @(negedge gclk);
      if (k == LAT) begin
        chk("cont_rsp0_valid", bus.rsp_valid, 1);
        chk("cont_rsp0_id", bus.rsp_id, 0);
        chk("cont_rsp0_prod", bus.rsp_product, 15);
      end
      if (k == LAT + 1) begin
        chk("cont_ready1", bus.req1_ready, 1);
        @(posedge gclk); #1 bus.req1_valid = 0;
      end
      if (k == LAT + 9) begin
        chk("cont_rsp1_valid", bus.rsp_valid, 1);
        chk("cont_rsp1_id", bus.rsp_id, 1);
        chk("cont_rsp1_prod", bus.rsp_product, 3825);
      end
    end

    // Fairness: both held valid for six jobs.
    do_reset();
    grants.delete();
    bus.req0_valid = 1; bus.req0_a = 8'd17; bus.req0_b = 4'd9;
    bus.req1_valid = 1; bus.req1_a = 8'd99; bus.req1_b = 4'd7;
    n = 0;
    do begin @(negedge gclk); #1; n++; end while (grants.size() < 6 && n < 200);
    chk("fair_timeout", n < 200, 1);
    @(posedge gclk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (LAT + 2) @(negedge gclk);
    for (int i = 0; i < 6; i++)
      chk($sformatf("fair_grant%0d", i), (i < grants.size()) ? grants[i] : -1, i % 2);
    chk("fair_jobs_done", bus.jobs_done, 6);

    // Reset during MULT: job discarded, then a fresh req1 job.
    @(posedge gclk); #1;
    bus.req0_valid = 1; bus.req0_a = 8'd7; bus.req0_b = 4'd9;
    @(negedge gclk);
    chk("mid_accept", bus.req0_ready, 1);
    @(posedge gclk); #1 bus.req0_valid = 0;
    repeat (3) @(negedge gclk);
    chk("mid_in_mult", bus.mul_multiply, 1);
    #2 grst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {bus.busy, bus.mul_write, bus.mul_multiply, bus.mul_display,
                        bus.rsp_valid, bus.rsp_id, bus.req0_ready, bus.req1_ready}, 0);
    chk("mid_rst_data", {bus.jobs_done, bus.rsp_product}, 0);
    chk("mid_rst_ops", {bus.mul_a, bus.mul_b}, 0);
    repeat (2) @(posedge gclk);
    #1 grst_n = 1'b1;
    one_job(1, 8'd10, 8'd10, lat, rid, prod);
    chk("mid_new_lat", lat, LAT);
    chk("mid_new_id", rid, 1);
    chk("mid_new_prod", prod, 100);
    chk("mid_new_jobs", bus.jobs_done, 1);

    // Random traffic; valid may drop before being granted.
    for (int c = 0; c < 400; c++) begin
      @(posedge gclk); #1;
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_a = AW'($urandom); bus.req0_b = BW'($urandom);
      bus.req1_a = AW'($urandom); bus.req1_b = BW'($urandom);
    end
    @(posedge gclk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (LAT + 3) @(negedge gclk);
    chk("rand_drained", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_mult_scheduler.md
# seq_mult_scheduler

Round-robin scheduler that shares one `sequential_multiplier` between two requesters. Each requester hands over an operand pair through a valid/ready handshake. The scheduler then sequences the multiplier's `write` → `multiply` → `display` controls, captures the product, and returns it tagged with the requester id. It sits directly in front of `sequential_multiplier`, and its multiplier-side ports connect one-to-one to that module's ports.

## Interface
- `A_WIDTH`, 8, width of operand a.
- `B_WIDTH`, 4, width of operand b.
- `MULT_CYCLES`, 4, number of cycles `multiply` is held high per job; legal values are 1..15.
- `clk`  in  1  master clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `req0_valid`, `req1_valid`  in  1  requester has a job pending.
- `req0_a`, `req1_a`  in  A_WIDTH  operand a.
- `req0_b`, `req1_b`  in  B_WIDTH  operand b.
- `req0_ready`, `req1_ready`  out  1  scheduler accepts this requester's job this cycle.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_id` and `rsp_product` are valid.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_product`  out  A_WIDTH+B_WIDTH  captured product.
- `busy`  out  1  high in every state except IDLE.
- `jobs_done`  out  16  count of completed jobs; wraps at 65535→0.
- `mul_a`  out  A_WIDTH  connects to multiplier `a`.
- `mul_b`  out  B_WIDTH  connects to multiplier `b`.
- `mul_write`, `mul_multiply`, `mul_display`  out  1  multiplier controls.
- `mul_out`  in  A_WIDTH+B_WIDTH  multiplier `out`.

## Operation
- **FSM states:** IDLE, LOAD, MULT, SHOW, DONE.
- **IDLE**
  - Grant selection: `ready` is high for exactly one requester, chosen as follows.
    - If only one requester has `valid` high, that requester gets `ready`.
    - If both have `valid` high, `ready` goes to the requester other than `last_grant`.
    - If neither has `valid` high, `ready` goes to the requester other than `last_grant`.
  - `ready` is combinational from `valid`, `state` and `last_grant`.
  - Handshake: `valid && ready` in IDLE. On a handshake the scheduler registers the operands into `mul_a`/`mul_b`, records `job_id`, updates `last_grant`, and moves to LOAD.
- **LOAD:** `mul_write=1` for one cycle, then MULT.
- **MULT:** `mul_multiply=1` while a 4-bit counter runs from `MULT_CYCLES-1` down to 0. At 0 → SHOW.
- **SHOW:** `mul_display=1` for two cycles. On the second cycle the scheduler registers `mul_out` into `rsp_product`, then → DONE.
- **DONE:** `rsp_valid=1` and `rsp_id=job_id` for one cycle. `jobs_done` increments; then → IDLE.
- **Control exclusivity:** at most one of `mul_write`/`mul_multiply`/`mul_display` is high in any cycle. All three are registered outputs.
- **Operand stability:** `mul_a`/`mul_b` hold their value from the handshake until the next handshake; they never change mid-job.
- **No backpressure:** there is no backpressure on the response. The requester must take the `rsp_valid` pulse.
- **Width rule:** the product is unsigned, A_WIDTH+B_WIDTH bits, with no truncation. 255×15=3825 fits 12 bits.
- **Input deassertion:** a requester that drops `valid` before a handshake loses nothing; no job is recorded.

## Timing
- **Reset:** on reset assertion, asynchronously and at any state including mid-job, the following values apply.
  - State → IDLE; the in-flight job is discarded and no `rsp_valid` is produced for it.
  - All outputs are 0: `req*_ready` (while `rst_n`=0), `rsp_valid`, `rsp_id`, `rsp_product`, `busy`, `jobs_done`, `mul_*`.
  - `last_grant` resets to 1, so requester 0 wins the first contest.
- **Latency:** let the handshake occur in cycle t.
  - t+1: LOAD.
  - t+2 … t+1+MULT_CYCLES: MULT.
  - Next two cycles: SHOW.
  - Following cycle: DONE (`rsp_valid`).
  - The cycle after that: IDLE; next handshake possible.
  - With the default MULT_CYCLES=4: `rsp_valid` at t+8, next accept at t+9. Throughput is one job per MULT_CYCLES+5 cycles.
- **`busy`:** rises at t+1 and falls in the cycle after DONE.
- **Simultaneous events:** `valid` arriving during a job is held off (`ready`=0) until IDLE. Arbitration happens only in IDLE.

## Test plan
- **Single job:** reset, then `req0` a=200, b=13 → at t+8 `rsp_valid=1`, `rsp_id=0`, `rsp_product=2600`, `jobs_done=1`.
- **Contention:** both requesters valid from reset release (`req0` 3×5, `req1` 255×15) → responses in order id 0 = 15 at cycle t+8, then id 1 = 3825 at cycle t+17.
- **Fairness:** both requesters held valid for 6 jobs → grants alternate 0,1,0,1,0,1. `jobs_done=6`, and no cycle has two `ready`s high.
- **Control sequence check:** for MULT_CYCLES=4, sample the multiplier controls per job → `write` for exactly 1 cycle, `multiply` for 4, `display` for 2, never overlapping. `mul_a`/`mul_b` stay stable throughout.
- **Reset mid-job:** assert `rst_n=0` during MULT → all outputs go to 0 immediately and no response appears. After release, a new `req1` job 10×10 returns 100 with `rsp_id=1`.
- **Counter wrap:** preload via 65536 jobs (or force `jobs_done=65535`) and complete one more job → `jobs_done=0`.
